// File: rtl/aes_model_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// aes_model_pack: AES-128 tables, shared types and round primitives. Rev 1.0
// ============================================================================
package aes_model_pack;

  localparam int DATA_WIDTH_IN_BYTES = 16;
  localparam int NUM_ROUNDS          = 10;

  typedef logic [8*DATA_WIDTH_IN_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_sched_state_e;

  // Index 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SUB_BYTES_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:NUM_ROUNDS-1][7:0] RCON_TABLE = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_state_t subbytes(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int k = 0; k < DATA_WIDTH_IN_BYTES; k++)
      r[8*k +: 8] = SUB_BYTES_TABLE[s[8*k +: 8]];
    return r;
  endfunction

  // Byte (row, col) lives at index row + 4*col; row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[8*(rw + 4*c) +: 8] = s[8*(rw + 4*((c + rw) % 4)) +: 8];
    return r;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = SUB_BYTES_TABLE[w[8*k +: 8]];
    return r;
  endfunction

  function automatic aes_state_t key_expand(input aes_state_t k, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    // RotWord of the last key word, expressed in LSB-first byte order.
    t  = sub_word({k[103:96], k[127:120], k[119:112], k[111:104]}) ^ {24'h0, rcon};
    n0 = k[31:0]   ^ t;
    n1 = k[63:32]  ^ n0;
    n2 = k[95:64]  ^ n1;
    n3 = k[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (round == 4'(i + 1)) v = RCON_TABLE[i];
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// aes_round_datapath: one combinational AES-128 round plus key expansion. Rev 1.0
// ============================================================================
module aes_round_datapath
  import aes_model_pack::*;
(
  input  aes_state_t state,
  input  aes_state_t key,
  input  logic [7:0] rcon,
  input  logic       last_round,
  output aes_state_t next_state,
  output aes_state_t next_key
);

  aes_state_t w_shifted;

  assign w_shifted  = shift_rows(subbytes(state));
  assign next_key   = key_expand(key, rcon);
  assign next_state = (last_round ? w_shifted : mix_columns(w_shifted)) ^ next_key;

endmodule
`default_nettype wire

// File: rtl/aes_round_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// aes_round_scheduler: iterative AES-128 encryptor, one round per clock. Rev 1.0
// ============================================================================
module aes_round_scheduler #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int NUM_ROUNDS          = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] in_data,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] in_key,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0] out_data,
  output logic                             busy,
  output logic [3:0]                       round_idx
);

  import aes_model_pack::*;

  aes_sched_state_e r_fsm;
  aes_state_t       r_state;
  aes_state_t       r_key;
  aes_state_t       w_next_state;
  aes_state_t       w_next_key;
  logic [7:0]       w_rcon;
  logic             w_last_round;

  assign w_rcon       = rcon_lookup(round_idx);
  assign w_last_round = (round_idx == 4'(NUM_ROUNDS));

  aes_round_datapath u_datapath (
    .state      (r_state),
    .key        (r_key),
    .rcon       (w_rcon),
    .last_round (w_last_round),
    .next_state (w_next_state),
    .next_key   (w_next_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm     <= IDLE;
      r_state   <= '0;
      r_key     <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round_idx <= 4'd0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_state   <= in_data ^ in_key;
            r_key     <= in_key;
            round_idx <= 4'd1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            r_fsm     <= ROUND;
          end
        end
        ROUND: begin
          r_state <= w_next_state;
          r_key   <= w_next_key;
          if (w_last_round) begin
            out_data  <= w_next_state;
            out_valid <= 1'b1;
            r_fsm     <= DONE;
          end else begin
            round_idx <= round_idx + 4'd1;
          end
        end
        DONE: begin
          // Input stays blocked here; a waiting pair is taken on the next IDLE cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            round_idx <= 4'd0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_fsm     <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_aes_round_scheduler: scoreboard bench with FIPS-197 vectors. Rev 1.0
// ============================================================================
module tb_aes_round_scheduler;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           accept_cyc = 0;
  int           outputs_seen = 0;
  int           exp_idx = 0;
  bit           mon_en = 1'b0;
  bit           prev_valid = 1'b0;
  logic [127:0] exp_q[$];

  aes_round_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIPS strings list byte 0 first; the bus carries byte 0 in the low bits.
  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[127-8*k -: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct, input bit push);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = fips(pt);
    in_key   = fips(key);
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) fail("accept_timeout");
    else begin
      accept_cyc = cyc;
      if (push) exp_q.push_back(fips(ct));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Monitor: round counter model, latency, and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      exp_idx    = 0;
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) check("latency", 128'(cyc - accept_cyc), 128'd10);
      prev_valid = out_valid;
      if (out_valid) check("round_idx_done", 128'(round_idx), 128'd10);
      else if (busy) begin
        exp_idx++;
        check("round_idx_seq", 128'(round_idx), 128'(exp_idx));
      end else begin
        exp_idx = 0;
        check("round_idx_idle", 128'(round_idx), 128'd0);
      end
      if (out_valid && out_ready) begin
        outputs_seen++;
        if (exp_q.size() == 0) fail("unexpected_output");
        else check("ciphertext", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_key = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_round_idx", 128'(round_idx), 128'd0);
    check("reset_out_data", out_data, 128'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send(PT_B, KEY_B, CT_B, 1'b1);
    in_valid = 1'b0;
    drain();
    send(PT_C, KEY_C, CT_C, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: hold out_ready low for 20 cycles of valid output.
    out_ready = 1'b0;
    send(PT_B, KEY_B, CT_B, 1'b1);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) fail("bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      check("bp_out_data", out_data, fips(CT_B));
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", 128'(in_ready), 128'd1);
    check("bp_idle_busy", 128'(busy), 128'd0);
    check("bp_idle_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high.
    send(PT_B, KEY_B, CT_B, 1'b1);
    a0 = accept_cyc;
    send(PT_C, KEY_C, CT_C, 1'b1);
    a1 = accept_cyc;
    send(PT_B, KEY_B, CT_B, 1'b1);
    a2 = accept_cyc;
    in_valid = 1'b0;
    drain();
    check("b2b_spacing_1", 128'(a1 - a0), 128'd12);
    check("b2b_spacing_2", 128'(a2 - a1), 128'd12);

    // Reset while round 5 is in flight; that block must never appear.
    send(PT_C, KEY_C, CT_C, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (round_idx != 4'd5) fail("round5_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    send(PT_B, KEY_B, CT_B, 1'b1);
    in_valid = 1'b0;
    drain();

    // Inputs wiggle during the rounds; only the sampled pair counts.
    send(PT_C, KEY_C, CT_C, 1'b1);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    check("outputs_seen", 128'(outputs_seen), 128'd8);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
